// File: rtl/stream_framer.sv
// Input stage of the blur pipeline: 2-entry skid buffer plus row/column framing tags and s_last checking.
// Optional `STREAM_FRAMER_RESYNC_EN adds a RESYNC state that drops beats after a late frame end.
module stream_framer #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned COLS  = 260,
    parameter int unsigned ROWS  = 258
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] s_data0,
    input  logic [WIDTH-1:0] s_data1,
    input  logic [WIDTH-1:0] s_data2,
    input  logic             s_valid,
    input  logic             s_last,
    output logic             s_ready,
    output logic [WIDTH-1:0] m_data0,
    output logic [WIDTH-1:0] m_data1,
    output logic [WIDTH-1:0] m_data2,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_sol,
    output logic             m_eol,
    output logic             m_sof,
    output logic             m_eof,
    output logic             err_early,
    output logic             err_late,
    output logic [15:0]      frame_cnt
);

    localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;

`ifdef STREAM_FRAMER_RESYNC_EN
    typedef enum logic {RUN = 1'b0, RESYNC = 1'b1} state_t;
`else
    typedef enum logic {RUN = 1'b0} state_t;
`endif

    typedef struct packed {
        logic [WIDTH-1:0] d0;
        logic [WIDTH-1:0] d1;
        logic [WIDTH-1:0] d2;
        logic             sol;
        logic             eol;
        logic             sof;
        logic             eof;
    } beat_t;

    state_t        state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [15:0]   frame_q, frame_d;
    logic          early_q, early_d;
    logic          late_q, late_d;
    logic [1:0]    occ_q, occ_d;
    logic          s_ready_q, s_ready_d;
    beat_t         head_q, head_d, skid_q, skid_d, nb;
    logic          in_fire, out_fire, push, keep, last_col, last_pos;

    assign in_fire  = s_valid & s_ready_q;
    assign out_fire = m_valid & m_ready;
    assign last_col = (col_q == CW'(COLS - 1));
    assign last_pos = last_col && (row_q == RW'(ROWS - 1));
    assign push     = in_fire & keep;

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        frame_d = frame_q;
        early_d = early_q;
        late_d  = late_q;
        keep    = 1'b1;
        nb.d0   = s_data0;
        nb.d1   = s_data1;
        nb.d2   = s_data2;
        nb.sol  = (col_q == '0);
        nb.eol  = last_col;
        nb.sof  = (col_q == '0) && (row_q == '0);
        nb.eof  = last_pos | s_last;
        if (in_fire) begin
            case (state_q)
                RUN: begin
                    if (last_pos) begin
                        col_d   = '0;
                        row_d   = '0;
                        frame_d = frame_q + 16'd1;
                        if (!s_last) begin
                            late_d = 1'b1;
`ifdef STREAM_FRAMER_RESYNC_EN
                            state_d = RESYNC;
`endif
                        end
                    end else if (s_last) begin
                        early_d = 1'b1;
                        col_d   = '0;
                        row_d   = '0;
                    end else if (last_col) begin
                        col_d = '0;
                        row_d = row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
`ifdef STREAM_FRAMER_RESYNC_EN
                RESYNC: begin
                    keep = 1'b0;
                    if (s_last) state_d = RUN;
                end
`endif
                default: state_d = RUN;
            endcase
        end
    end

    // Head is the output register; the skid entry only fills when the head is stalled.
    always_comb begin
        head_d = head_q;
        skid_d = skid_q;
        occ_d  = occ_q;
        case ({push, out_fire})
            2'b10: begin
                if (occ_q == 2'd0) head_d = nb;
                else               skid_d = nb;
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                head_d = skid_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b11: head_d = nb;
            default: ;
        endcase
        s_ready_d = (occ_d < 2'd2);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= RUN;
            col_q     <= '0;
            row_q     <= '0;
            frame_q   <= '0;
            early_q   <= 1'b0;
            late_q    <= 1'b0;
            occ_q     <= '0;
            s_ready_q <= 1'b0;
            head_q    <= '0;
            skid_q    <= '0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            frame_q   <= frame_d;
            early_q   <= early_d;
            late_q    <= late_d;
            occ_q     <= occ_d;
            s_ready_q <= s_ready_d;
            head_q    <= head_d;
            skid_q    <= skid_d;
        end
    end

    assign s_ready   = s_ready_q;
    assign m_valid   = (occ_q != 2'd0);
    assign m_data0   = head_q.d0;
    assign m_data1   = head_q.d1;
    assign m_data2   = head_q.d2;
    assign m_sol     = head_q.sol;
    assign m_eol     = head_q.eol;
    assign m_sof     = head_q.sof;
    assign m_eof     = head_q.eof;
    assign err_early = early_q;
    assign err_late  = late_q;
    assign frame_cnt = frame_q;

endmodule

// File: tb/tb_stream_framer.sv
// Self-checking bench for stream_framer (COLS=4, ROWS=3) against a linear-index frame model.
module tb_stream_framer;
    localparam int W = 8;
    localparam int C = 4;
    localparam int R = 3;
    localparam int N = C * R;

    typedef logic [3*W+3:0] beat_t;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] s_data0, s_data1, s_data2;
    logic         s_valid, s_last, s_ready;
    logic [W-1:0] m_data0, m_data1, m_data2;
    logic         m_valid, m_ready;
    logic         m_sol, m_eol, m_sof, m_eof;
    logic         err_early, err_late;
    logic [15:0]  frame_cnt;

    always #5 clk = ~clk;

    stream_framer #(.WIDTH(W), .COLS(C), .ROWS(R)) dut (
        .clk(clk), .reset(reset),
        .s_data0(s_data0), .s_data1(s_data1), .s_data2(s_data2),
        .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .m_data0(m_data0), .m_data1(m_data1), .m_data2(m_data2),
        .m_valid(m_valid), .m_ready(m_ready),
        .m_sol(m_sol), .m_eol(m_eol), .m_sof(m_sof), .m_eof(m_eof),
        .err_early(err_early), .err_late(err_late), .frame_cnt(frame_cnt)
    );

    int          total = 0;
    int          bad = 0;
    int          acc_cnt = 0;
    int          p = 0;
    bit          rs = 0;
    bit          m_early = 0;
    bit          m_late = 0;
    logic [15:0] m_frames = '0;
    bit          stalled_prev = 0;
    beat_t       held;
    logic [W-1:0] last_d0;
    beat_t       exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic beat_t out_now();
        return {m_data0, m_data1, m_data2, m_sol, m_eol, m_sof, m_eof};
    endfunction

    // Frame position is a single linear index; column/start/end flags derive from it.
    task automatic model_in(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c, input logic l);
        int  col;
        logic fin;
        acc_cnt++;
        if (rs) begin
            if (l) rs = 0;
        end else begin
            col = p % C;
            fin = (p == N - 1);
            exp_q.push_back({a, b, c, col == 0, col == C - 1, p == 0, fin | l});
            if (fin) begin
                m_frames = m_frames + 16'd1;
                if (!l) begin
                    m_late = 1;
`ifdef STREAM_FRAMER_RESYNC_EN
                    rs = 1;
`endif
                end
                p = 0;
            end else if (l) begin
                m_early = 1;
                p = 0;
            end else begin
                p++;
            end
        end
    endtask

    task automatic tick();
        beat_t cur;
        @(negedge clk);
        if (reset) begin
            cur = out_now();
            if (stalled_prev) check("stall_hold", 64'(cur), 64'(held));
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) check("spurious_out", 64'(m_valid), 64'(1'b0));
                else check("out_beat", 64'(cur), 64'(exp_q.pop_front()));
            end
            if (s_valid && s_ready) model_in(s_data0, s_data1, s_data2, s_last);
            stalled_prev = m_valid && !m_ready;
            held = cur;
        end else begin
            stalled_prev = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic l, input int mr);
        int start;
        start = acc_cnt;
        s_valid = 1'b1;
        s_data0 = W'($urandom);
        s_data1 = W'($urandom);
        s_data2 = W'($urandom);
        s_last  = l;
        last_d0 = s_data0;
        for (int i = 0; i < 300 && acc_cnt == start; i++) begin
            if (mr == 2) m_ready = 1'($urandom_range(0, 1));
            tick();
        end
        check("accept", 64'(acc_cnt), 64'(start + 1));
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic frame(input int nb, input int last_at, input int gmin, input int gmax, input int mr);
        int g;
        for (int k = 1; k <= nb; k++) begin
            g = (gmax == 0) ? 0 : int'($urandom_range(gmin, gmax));
            for (int j = 0; j < g; j++) begin
                s_valid = 1'b0;
                if (mr == 2) m_ready = 1'($urandom_range(0, 1));
                tick();
            end
            send(k == last_at, mr);
        end
    endtask

    task automatic drain();
        m_ready = 1'b1;
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick();
        check("drain", 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        int start;
        int prev;
        reset = 1'b0; s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b0;
        s_data0 = '0; s_data1 = '0; s_data2 = '0;
        #12;
        check("rst_m_valid", 64'(m_valid), 64'(0));
        check("rst_s_ready", 64'(s_ready), 64'(0));
        check("rst_flags", 64'({m_sol, m_eol, m_sof, m_eof}), 64'(0));
        check("rst_data", 64'({m_data0, m_data1, m_data2}), 64'(0));
        check("rst_errs", 64'({err_early, err_late}), 64'(0));
        check("rst_frame_cnt", 64'(frame_cnt), 64'(0));
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        check("s_ready_after_rst", 64'(s_ready), 64'(1));

        // contiguous frame, each beat visible one cycle after acceptance
        m_ready = 1'b1;
        for (int k = 1; k <= N; k++) begin
            send(k == N, 1);
            check("lat_valid", 64'(m_valid), 64'(1));
            check("lat_data", 64'(m_data0), 64'(last_d0));
        end
        drain();
        check("f1_frame_cnt", 64'(frame_cnt), 64'(1));
        check("f1_errs", 64'({err_early, err_late}), 64'(0));

        // output stall absorbs exactly two beats
        m_ready = 1'b0; s_valid = 1'b1; s_last = 1'b0;
        s_data0 = W'($urandom); s_data1 = W'($urandom); s_data2 = W'($urandom);
        start = acc_cnt;
        for (int i = 0; i < 10; i++) begin
            prev = acc_cnt;
            tick();
            if (i == 0) check("stall_ready_first", 64'(s_ready), 64'(1));
            if (acc_cnt != prev) begin
                s_data0 = W'($urandom); s_data1 = W'($urandom); s_data2 = W'($urandom);
            end
        end
        check("stall_accepted", 64'(acc_cnt - start), 64'(2));
        check("stall_ready_low", 64'(s_ready), 64'(0));
        s_valid = 1'b0; m_ready = 1'b1;
        tick();
        check("ready_restore", 64'(s_ready), 64'(1));
        for (int k = 3; k <= N; k++) send(k == N, 1);
        drain();
        check("stall_frame_cnt", 64'(frame_cnt), 64'(m_frames));

        // random gaps and backpressure
        frame(N, N, 1, 32, 2);
        frame(N, N, 1, 32, 2);
        drain();
        check("rand_frame_cnt", 64'(frame_cnt), 64'(m_frames));
        for (int f = 0; f < 4; f++) frame(N, N, 0, 2, 2);
        drain();
        check("dense_frame_cnt", 64'(frame_cnt), 64'(m_frames));
        check("rand_errs", 64'({err_early, err_late}), 64'(0));

        // early s_last on beat 7
        m_ready = 1'b1;
        frame(7, 7, 0, 0, 1);
        frame(N, N, 0, 0, 1);
        drain();
        check("early_err_early", 64'(err_early), 64'(1));
        check("early_err_late", 64'(err_late), 64'(m_late));
        check("early_frame_cnt", 64'(frame_cnt), 64'(m_frames));

        // missing s_last at frame end, s_last on beat 15
        frame(15, 15, 0, 0, 1);
        frame(N, N, 0, 0, 1);
        drain();
        check("late_err_late", 64'(err_late), 64'(1));
        check("late_err_early", 64'(err_early), 64'(m_early));
        check("late_frame_cnt", 64'(frame_cnt), 64'(m_frames));

        // asynchronous reset with two beats buffered
        frame(5, 0, 0, 0, 1);
        drain();
        m_ready = 1'b0;
        send(1'b0, 0);
        send(1'b0, 0);
        check("pre_rst_s_ready", 64'(s_ready), 64'(0));
        #2 reset = 1'b0;
        #1;
        check("mid_rst_m_valid", 64'(m_valid), 64'(0));
        check("mid_rst_s_ready", 64'(s_ready), 64'(0));
        check("mid_rst_errs", 64'({err_early, err_late}), 64'(0));
        check("mid_rst_frame_cnt", 64'(frame_cnt), 64'(0));
        check("mid_rst_flags", 64'({m_sol, m_eol, m_sof, m_eof}), 64'(0));
        exp_q.delete();
        p = 0; rs = 0; m_early = 0; m_late = 0; m_frames = '0; stalled_prev = 0;
        @(posedge clk); @(posedge clk); #1;
        check("hold_rst_s_ready", 64'(s_ready), 64'(0));
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        check("post_rst_s_ready", 64'(s_ready), 64'(1));
        m_ready = 1'b1;
        send(1'b0, 1);
        check("post_rst_sof", 64'({m_valid, m_sof, m_sol}), 64'(3'b111));
        for (int k = 2; k <= N; k++) send(k == N, 1);
        drain();
        check("post_rst_frame_cnt", 64'(frame_cnt), 64'(1));
        check("post_rst_errs", 64'({err_early, err_late}), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
